dec_lcd_writer: RTL and testbench

Downstream display stage for the CORDIC result path. Takes the sign, integer digit and seven fractional BCD digits produced by the binary-fraction-to-decimal stage, and writes them as one 10-character line to an HD44780-style character LCD. The LCD runs in 8-bit write-only mode. The block sequences one address command plus ten character writes, with programmable setup, enable-pulse and gap timing, and reports completion with a busy/done handshake.

---
 rtl/dec_lcd_writer.sv | 176 +++++++++++++++++
 tb/tb_dec_lcd_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dec_lcd_writer.sv
// Writes a signed 1.7-digit decimal value as one 10-character line to an
// HD44780-style LCD in 8-bit write-only mode.
module dec_lcd_writer #(
  parameter logic [15:0] SETUP_CYCLES = 16'd2,
  parameter logic [15:0] EN_CYCLES    = 16'd12,
  parameter logic [15:0] GAP_CYCLES   = 16'd2000,
  parameter logic [6:0]  LINE_ADDR    = 7'h40
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       start_i,
  input  logic       sign_i,
  input  logic [3:0] int_i,
  input  logic [3:0] z0,
  input  logic [3:0] z1,
  input  logic [3:0] z2,
  input  logic [3:0] z3,
  input  logic [3:0] z4,
  input  logic [3:0] z5,
  input  logic [3:0] z6,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ENH,
    GAP
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd10;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic             sign_q, sign_d;
  logic [3:0]       int_q, int_d;
  logic [6:0][3:0]  frac_q, frac_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d <= 4'd9) ? {4'h3, d} : 8'h23;
  endfunction

  // Byte for a given transfer slot: address command, sign, integer, point, fraction.
  function automatic logic [7:0] slot_char(
    input logic            [3:0] idx,
    input logic                  sgn,
    input logic            [3:0] ival,
    input logic [6:0][3:0]       frac
  );
    logic [7:0] c;
    case (idx)
      4'd0:    c = {1'b1, LINE_ADDR};
      4'd1:    c = sgn ? 8'h2D : 8'h2B;
      4'd2:    c = digit_char(ival);
      4'd3:    c = 8'h2E;
      4'd4:    c = digit_char(frac[0]);
      4'd5:    c = digit_char(frac[1]);
      4'd6:    c = digit_char(frac[2]);
      4'd7:    c = digit_char(frac[3]);
      4'd8:    c = digit_char(frac[4]);
      4'd9:    c = digit_char(frac[5]);
      default: c = digit_char(frac[6]);
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    sign_d  = sign_q;
    int_d   = int_q;
    frac_d  = frac_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_q;
    rs_d    = rs_q;
    en_d    = en_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = SETUP;
          idx_d   = '0;
          sign_d  = sign_i;
          int_d   = int_i;
          frac_d  = {z6, z5, z4, z3, z2, z1, z0};
          busy_d  = 1'b1;
          data_d  = {1'b1, LINE_ADDR};
          rs_d    = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_CYCLES - 16'd1) begin
          state_d = ENH;
          cnt_d   = '0;
          en_d    = 1'b1;
        end
      end
      ENH: begin
        if (cnt_q == EN_CYCLES - 16'd1) begin
          state_d = GAP;
          cnt_d   = '0;
          en_d    = 1'b0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_CYCLES - 16'd1) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = SETUP;
            idx_d   = idx_q + 4'd1;
            data_d  = slot_char(idx_q + 4'd1, sign_q, int_q, frac_q);
            rs_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sign_q  <= 1'b0;
      int_q   <= '0;
      frac_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sign_q  <= sign_d;
      int_q   <= int_d;
      frac_q  <= frac_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign lcd_data_o = data_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = en_q;

endmodule

// File: tb/tb_dec_lcd_writer.sv
// Directed bench for dec_lcd_writer with SETUP=2, EN=3, GAP=4 (T=9).
module tb_dec_lcd_writer;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic       start_i;
  logic       sign_i;
  logic [3:0] int_i;
  logic [3:0] z0, z1, z2, z3, z4, z5, z6;
  logic       busy_o, done_o;
  logic [7:0] lcd_data_o;
  logic       lcd_rs_o, lcd_rw_o, lcd_en_o;

  dec_lcd_writer #(
    .SETUP_CYCLES(16'd2),
    .EN_CYCLES   (16'd3),
    .GAP_CYCLES  (16'd4),
    .LINE_ADDR   (7'h40)
  ) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .start_i   (start_i),
    .sign_i    (sign_i),
    .int_i     (int_i),
    .z0        (z0),
    .z1        (z1),
    .z2        (z2),
    .z3        (z3),
    .z4        (z4),
    .z5        (z5),
    .z6        (z6),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .lcd_data_o(lcd_data_o),
    .lcd_rs_o  (lcd_rs_o),
    .lcd_rw_o  (lcd_rw_o),
    .lcd_en_o  (lcd_en_o)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int         passed = 0;
  int         total  = 0;
  logic [8:0] cap[$];
  logic [8:0] last_byte = '0;
  logic       prev_en = 1'b0;
  int         en_pulses = 0;
  int         stab_err = 0;
  int         busy_cnt = 0;
  int         first_en_cyc = -1;

  // Captures {rs,data} on every EN rise and flags any bus change while EN is high or falling.
  always @(negedge iCLK) begin
    if (lcd_en_o && !prev_en) begin
      if (cap.size() == 0) first_en_cyc = cyc;
      last_byte = {lcd_rs_o, lcd_data_o};
      cap.push_back(last_byte);
      en_pulses++;
    end else if ((lcd_en_o || prev_en) && iRST_N && ({lcd_rs_o, lcd_data_o} !== last_byte)) begin
      stab_err++;
    end
    if (busy_o) busy_cnt++;
    prev_en = lcd_en_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic apply_stimulus(input logic s, input logic [3:0] i,
                                input logic [3:0] a0, input logic [3:0] a1,
                                input logic [3:0] a2, input logic [3:0] a3,
                                input logic [3:0] a4, input logic [3:0] a5,
                                input logic [3:0] a6);
    sign_i = s; int_i = i;
    z0 = a0; z1 = a1; z2 = a2; z3 = a3; z4 = a4; z5 = a5; z6 = a6;
  endtask

  task automatic clear_monitor();
    cap.delete();
    en_pulses    = 0;
    stab_err     = 0;
    busy_cnt     = 0;
    first_en_cyc = -1;
  endtask

  task automatic pulse_start(output int k);
    @(negedge iCLK);
    start_i = 1'b1;
    k = cyc;
    @(negedge iCLK);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int at);
    logic found;
    found = 1'b0;
    at = -1;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge iCLK);
      if (done_o) begin
        found = 1'b1;
        at = cyc;
      end
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic check_output(input string tag, input int base, input logic [8:0] exp [11]);
    logic [31:0] obs;
    for (int i = 0; i < 11; i++) begin
      obs = 'x;
      if (cap.size() > base + i) obs = {23'd0, cap[base + i]};
      check($sformatf("%s_byte%0d", tag, i), obs, {23'd0, exp[i]});
    end
    check({tag, "_stable"}, stab_err, 0);
  endtask

  logic [8:0] v_basic [11];
  logic [8:0] v_neg9  [11];
  logic [8:0] v_badz  [11];
  logic [8:0] v_latch [11];
  int k, at;

  initial begin
    v_basic = '{9'h0C0, 9'h12B, 9'h130, 9'h12E, 9'h137, 9'h130, 9'h137, 9'h131, 9'h130, 9'h136, 9'h138};
    v_neg9  = '{9'h0C0, 9'h12D, 9'h131, 9'h12E, 9'h139, 9'h139, 9'h139, 9'h139, 9'h139, 9'h139, 9'h139};
    v_badz  = '{9'h0C0, 9'h12B, 9'h135, 9'h12E, 9'h131, 9'h132, 9'h133, 9'h123, 9'h134, 9'h135, 9'h136};
    v_latch = '{9'h0C0, 9'h12D, 9'h138, 9'h12E, 9'h130, 9'h131, 9'h132, 9'h133, 9'h134, 9'h135, 9'h136};

    iRST_N  = 1'b0;
    start_i = 1'b0;
    apply_stimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge iCLK);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_data", {24'd0, lcd_data_o}, 32'h00);
    check("rst_rs",   {31'd0, lcd_rs_o}, 32'd0);
    check("rst_rw",   {31'd0, lcd_rw_o}, 32'd0);
    check("rst_en",   {31'd0, lcd_en_o}, 32'd0);
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);

    $display("[TB] basic line +0.7071068");
    apply_stimulus(1'b0, 4'd0, 4'd7, 4'd0, 4'd7, 4'd1, 4'd0, 4'd6, 4'd8);
    clear_monitor();
    pulse_start(k);
    wait_done("basic_done", at);
    check("basic_done_cycle", at - k, 32'd100);
    check("basic_busy_cycles", busy_cnt, 32'd99);
    check("basic_first_en", first_en_cyc - k, 32'd3);
    check("basic_busy_at_done", {31'd0, busy_o}, 32'd0);
    check("basic_pulses", en_pulses, 32'd11);
    check_output("basic", 0, v_basic);
    @(negedge iCLK);
    check("basic_done_pulse", {31'd0, done_o}, 32'd0);

    $display("[TB] negative line -1.9999999");
    apply_stimulus(1'b1, 4'd1, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
    clear_monitor();
    pulse_start(k);
    wait_done("neg9_done", at);
    check("neg9_pulses", en_pulses, 32'd11);
    check_output("neg9", 0, v_neg9);

    $display("[TB] non-BCD digit maps to #");
    apply_stimulus(1'b0, 4'd5, 4'd1, 4'd2, 4'd3, 4'hC, 4'd4, 4'd5, 4'd6);
    clear_monitor();
    pulse_start(k);
    wait_done("badz_done", at);
    check_output("badz", 0, v_badz);

    $display("[TB] inputs latched at start, restart ignored while busy");
    apply_stimulus(1'b1, 4'd8, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    clear_monitor();
    pulse_start(k);
    for (int n = 0; n < 200 && cap.size() < 6; n++) @(negedge iCLK);
    check("latch_reach_t5", cap.size(), 32'd6);
    apply_stimulus(1'b0, 4'd2, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
    start_i = 1'b1;
    @(negedge iCLK);
    start_i = 1'b0;
    wait_done("latch_done", at);
    check_output("latch", 0, v_latch);
    repeat (40) @(negedge iCLK);
    check("latch_no_requeue_pulses", en_pulses, 32'd11);
    check("latch_no_requeue_busy", {31'd0, busy_o}, 32'd0);

    $display("[TB] reset during ENH of transfer 4");
    apply_stimulus(1'b0, 4'd0, 4'd7, 4'd0, 4'd7, 4'd1, 4'd0, 4'd6, 4'd8);
    clear_monitor();
    pulse_start(k);
    for (int n = 0; n < 200 && cap.size() < 5; n++) @(negedge iCLK);
    check("rstmid_in_enh", {31'd0, lcd_en_o}, 32'd1);
    iRST_N = 1'b0;
    @(negedge iCLK);
    check("rstmid_busy", {31'd0, busy_o}, 32'd0);
    check("rstmid_done", {31'd0, done_o}, 32'd0);
    check("rstmid_data", {24'd0, lcd_data_o}, 32'h00);
    check("rstmid_rs",   {31'd0, lcd_rs_o}, 32'd0);
    check("rstmid_en",   {31'd0, lcd_en_o}, 32'd0);
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
    clear_monitor();
    pulse_start(k);
    wait_done("rstmid_after_done", at);
    check("rstmid_after_pulses", en_pulses, 32'd11);
    check_output("rstmid_after", 0, v_basic);

    $display("[TB] back-to-back with start held high");
    clear_monitor();
    @(negedge iCLK);
    start_i = 1'b1;
    k = cyc;
    wait_done("b2b_first_done", at);
    check("b2b_first_done_cycle", at - k, 32'd100);
    check("b2b_busy_low_at_done", {31'd0, busy_o}, 32'd0);
    @(negedge iCLK);
    start_i = 1'b0;
    check("b2b_second_busy_rise", {31'd0, busy_o}, 32'd1);
    wait_done("b2b_second_done", at);
    check("b2b_second_done_cycle", at - k, 32'd200);
    check("b2b_pulses", en_pulses, 32'd22);
    check_output("b2b_first", 0, v_basic);
    check_output("b2b_second", 11, v_basic);

    repeat (5) @(negedge iCLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
